i2s_rx_deser: RTL and testbench
===============================

Name: i2s_rx_deser

Overview:
- Upstream stage of the equalizer digital core. Deserializes the codec's I2S ADC stream (SCLK, LRCLK, SDin; codec is bus master) into coherent signed left/right sample pairs.
- Issues a one-clk `valid` strobe per stereo frame. The pair and strobe drive the core's `lft_in`/`rht_in`/`valid` (circular-buffer write).
- Runs entirely on the system clock. The I2S pins are oversampled: synchronized, then edge-detected.

Parameters:
- DATA_W, 24: bits per channel word transmitted by the codec, MSB first.
- OUT_W, 16: output sample width; the upper OUT_W bits of the received word, no rounding. Legal when OUT_W <= DATA_W.

Ports:
- clk  input  1  system clock. Single clock domain; SCLK frequency <= clk/8.
- rst_n  input  1  reset, asynchronous, active-low.
- SCLK  input  1  I2S bit clock from codec (asynchronous to clk).
- LRCLK  input  1  I2S word select; 0 = left half, 1 = right half (asynchronous).
- SDin  input  1  I2S serial data (asynchronous).
- lft_smpl  output  OUT_W  signed left sample; held between frames.
- rht_smpl  output  OUT_W  signed right sample; held between frames.
- valid  output  1  one-clk pulse; lft_smpl/rht_smpl hold a new coherent pair.
- frame_err  output  1  sticky short-frame flag (see Optional Feature).

Behaviour:
- Input conditioning:
  - SCLK, LRCLK and SDin each pass through 2 flops, plus a third SCLK flop for edge detect.
  - `sclk_rise` = sync2 & ~sync3.
  - All protocol actions happen only in cycles where sclk_rise=1, using the synchronized LRCLK/SDin values from that same cycle.
- lr_prev register: LRCLK value captured at each sclk_rise.
  - A sclk_rise with LRCLK != lr_prev is the I2S delay bit. SDin is ignored, bit counter cnt cleared to 0.
- Bit shifting:
  - Subsequent sclk_rise with cnt < DATA_W: shift SDin into a DATA_W shift register (MSB first), cnt++.
  - Once cnt == DATA_W, further bits in that half are ignored. Codec slot widths 24..32 are legal.
- FSM states: SYNC, LEFT, RIGHT.
  - SYNC → LEFT: on a delay bit where LRCLK goes 1→0. All other activity in SYNC is ignored; the first partial frame after reset is discarded.
  - LEFT → RIGHT: on a delay bit with LRCLK 0→1. If cnt reached DATA_W in LEFT, `lft_stage` has already latched shreg[DATA_W-1 -: OUT_W] on the cycle cnt became DATA_W.
  - RIGHT → LEFT: on a delay bit with LRCLK 1→0.
- Frame completion and latency:
  - On the sclk_rise that makes cnt == DATA_W in RIGHT, set `done` if the left half of the same frame was complete.
  - On the next clk: lft_smpl <= lft_stage, rht_smpl <= shreg upper OUT_W bits, valid = 1 for exactly one clk.
  - The two outputs always change together and the values never tear.
- Short half (LRCLK toggles with cnt < DATA_W):
  - That word is discarded.
  - If the left half was short, the following right half produces no valid.
- Reset values: lft_smpl = 0, rht_smpl = 0, valid = 0, frame_err = 0, state = SYNC, cnt = 0, lr_prev = 1, synchronizer flops = 0.
- Reset asserted mid-frame: immediate return to reset values; no valid is issued for the interrupted frame.
- Minimum frame spacing is 2×(DATA_W+1) SCLKs; valid never pulses in two consecutive clks.

Optional Feature:
- Macro I2S_FRAME_ERR_EN.
- Defined:
  - Any short half, or an LRCLK toggle in LEFT/RIGHT in the wrong direction, sets frame_err = 1 (sticky until rst_n).
  - The FSM returns to SYNC, and valid is suppressed until a full left+right frame completes after resync.
- Undefined: frame_err is tied 0; a short half is silently discarded and the FSM keeps tracking LRCLK as above.

Decomposition:
- Shared package eq_pkg holds:
  - the `i2s_state_t` enum {SYNC, LEFT, RIGHT};
  - I2S_DATA_W = 24 and SMPL_W = 16, used as parameter defaults;
  - SCLK_MIN_DIV = 8 for bench assertions.
- One sub-module, `sync_edge`: 2-flop synchronizer plus registered delay. Outputs: sync value, rise pulse, fall pulse.
  - Instantiated for SCLK (edges) and LRCLK (sync value only); SDin uses the sync value only.

Test Plan:
- Nominal frame, no gap: DATA_W = 24, SCLK = clk/16, 32-bit slots, left 0x123456, right 0xABCDEF → one valid pulse with lft_smpl = 0x1234, rht_smpl = 0xABCD (signed negative).
- Mid-frame start: release rst_n while LRCLK = 1 partway through the right half → no valid until a full left+right completes; the first pair is correct.
- Back-to-back frames: 3 frames (0x7FFFFF/0x800000, 0x000100/0xFFFF00, 0x55AA55/0xAA55AA) → exactly 3 valid pulses, each 64 SCLKs apart, with outputs 0x7FFF/0x8000, 0x0001/0xFFFF, 0x55AA/0xAA55. Bits 25..32 of each slot are ignored.
- Short left half: 20 bits, then right half 0x111111.
  - With I2S_FRAME_ERR_EN: frame_err = 1, no valid; the next good frame yields valid.
  - Without the macro: no valid for that frame, frame_err = 0.
- Reset mid-right-half, then released → outputs 0 and valid 0 immediately; normal operation resumes after the SYNC → LEFT delay bit.

Source files
------------

// File: rtl/eq_pkg.sv
// Shared types and defaults for the equalizer core front end (I2S receive path).
package eq_pkg;

    typedef enum logic [1:0] {
        SYNC,
        LEFT,
        RIGHT
    } i2s_state_t;

    localparam int I2S_DATA_W   = 24;
    localparam int SMPL_W       = 16;
    localparam int SCLK_MIN_DIV = 8;

endpackage

// File: rtl/i2s_rx_deser_sync_edge.sv
// Two-flop synchronizer with one extra delay flop; provides the synced level
// plus single-clk rise/fall pulses.
module sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic s1, s2, s3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= d;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign q    = s2;
    assign rise = s2 & ~s3;
    assign fall = ~s2 & s3;

endmodule

// File: rtl/i2s_rx_deser.sv
// I2S ADC receiver: oversamples SCLK/LRCLK/SDin on clk and emits coherent
// left/right pairs with a one-clk valid. Define I2S_FRAME_ERR_EN for frame_err.
module i2s_rx_deser
    import eq_pkg::*;
#(
    parameter int DATA_W = I2S_DATA_W,
    parameter int OUT_W  = SMPL_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             SCLK,
    input  logic             LRCLK,
    input  logic             SDin,
    output logic [OUT_W-1:0] lft_smpl,
    output logic [OUT_W-1:0] rht_smpl,
    output logic             valid,
    output logic             frame_err
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);

    logic sclk_rise, sclk_q_unused, sclk_fall_unused;
    logic lr_s, lr_rise_unused, lr_fall_unused;
    logic sd_s, sd_rise_unused, sd_fall_unused;

    sync_edge u_sclk (.clk(clk), .rst_n(rst_n), .d(SCLK),
                      .q(sclk_q_unused), .rise(sclk_rise), .fall(sclk_fall_unused));
    sync_edge u_lrclk (.clk(clk), .rst_n(rst_n), .d(LRCLK),
                       .q(lr_s), .rise(lr_rise_unused), .fall(lr_fall_unused));
    sync_edge u_sdin (.clk(clk), .rst_n(rst_n), .d(SDin),
                      .q(sd_s), .rise(sd_rise_unused), .fall(sd_fall_unused));

    i2s_state_t        state, state_nxt;
    logic              lr_prev;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] shreg, shreg_nxt;
    logic [OUT_W-1:0]  lft_stage;
    logic              left_ok, done;
    logic              delay_bit, shift_en, word_done, err_evt;

    // The first SCLK rise after an LRCLK change carries the previous word's LSB.
    assign delay_bit = sclk_rise & (lr_s != lr_prev);
    assign shift_en  = sclk_rise & ~delay_bit & (cnt != CNT_FULL);
    assign word_done = shift_en & (cnt == CNT_FULL - 1'b1);
    assign shreg_nxt = {shreg[DATA_W-2:0], sd_s};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= SYNC;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        err_evt   = 1'b0;
`ifdef I2S_FRAME_ERR_EN
        if (delay_bit && state != SYNC)
            err_evt = (cnt != CNT_FULL) || (state == LEFT && !lr_s) || (state == RIGHT && lr_s);
`endif
        case (state)
            SYNC:    if (delay_bit && !lr_s) state_nxt = LEFT;
            LEFT:    if (delay_bit && lr_s)  state_nxt = RIGHT;
            RIGHT:   if (delay_bit && !lr_s) state_nxt = LEFT;
            default: state_nxt = SYNC;
        endcase
        if (err_evt) state_nxt = SYNC;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lr_prev   <= 1'b1;
            cnt       <= '0;
            shreg     <= '0;
            lft_stage <= '0;
            left_ok   <= 1'b0;
            done      <= 1'b0;
            valid     <= 1'b0;
            lft_smpl  <= '0;
            rht_smpl  <= '0;
        end else begin
            done  <= 1'b0;
            valid <= done;
            // shreg is frozen once the right word is full, so it is safe to read here
            if (done) begin
                lft_smpl <= lft_stage;
                rht_smpl <= shreg[DATA_W-1 -: OUT_W];
            end
            if (sclk_rise) lr_prev <= lr_s;
            if (delay_bit) begin
                cnt <= '0;
                if (state_nxt != RIGHT) left_ok <= 1'b0;
            end else if (shift_en) begin
                shreg <= shreg_nxt;
                cnt   <= cnt + 1'b1;
                if (word_done && state == LEFT) begin
                    lft_stage <= shreg_nxt[DATA_W-1 -: OUT_W];
                    left_ok   <= 1'b1;
                end
                if (word_done && state == RIGHT && left_ok) begin
                    done    <= 1'b1;
                    left_ok <= 1'b0;
                end
            end
        end
    end

`ifdef I2S_FRAME_ERR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       frame_err <= 1'b0;
        else if (err_evt) frame_err <= 1'b1;
    end
`else
    assign frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_i2s_rx_deser.sv
// Directed-vector bench for i2s_rx_deser: codec model drives I2S, a monitor
// checks each valid pair against a queue of expected pairs.
module tb_i2s_rx_deser;
    import eq_pkg::*;

    localparam int CLK_PER   = 10;
    localparam int SCLK_HALF = 80;   // SCLK = clk/16
    localparam int SLOT      = 32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        SCLK = 1'b0;
    logic        LRCLK = 1'b1;
    logic        SDin = 1'b0;
    logic [15:0] lft_smpl, rht_smpl;
    logic        valid, frame_err;

    i2s_rx_deser #(.DATA_W(24), .OUT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .SCLK(SCLK), .LRCLK(LRCLK), .SDin(SDin),
        .lft_smpl(lft_smpl), .rht_smpl(rht_smpl), .valid(valid), .frame_err(frame_err)
    );

    always #(CLK_PER/2) clk = ~clk;

    initial assert (2 * SCLK_HALF >= SCLK_MIN_DIV * CLK_PER);

    typedef struct packed {
        logic [15:0] l;
        logic [15:0] r;
    } pair_t;

    pair_t  exp_q[$];
    longint vt[$];
    int     n_pass = 0;
    int     n_tot  = 0;
    logic   valid_d = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a pair.
    always @(negedge clk) begin : monitor
        pair_t e;
        if (valid) begin
            vt.push_back($time);
            chk("valid_single_cycle", {31'b0, valid_d}, 32'd0);
            if (exp_q.size() == 0) begin
                n_tot++;
                $display("FAIL unexpected_valid: got lft=%h rht=%h expected no pulse at %0t",
                         lft_smpl, rht_smpl, $time);
            end else begin
                e = exp_q.pop_front();
                chk("lft_smpl", {16'b0, lft_smpl}, {16'b0, e.l});
                chk("rht_smpl", {16'b0, rht_smpl}, {16'b0, e.r});
            end
        end
        valid_d = valid;
    end

    task automatic bitcyc(input logic ch, input logic d);
        SCLK  = 1'b0;
        LRCLK = ch;
        SDin  = d;
        #SCLK_HALF;
        SCLK = 1'b1;
        #SCLK_HALF;
    endtask

    // One I2S half: delay bit, nbits MSB-first data bits, random filler to slot.
    task automatic half(input logic ch, input logic [23:0] w, input int nbits, input int slot);
        logic d;
        for (int k = 0; k < slot; k++) begin
            if (k == 0)          d = 1'b0;
            else if (k <= nbits) d = w[24-k];
            else                 d = 1'($urandom_range(0, 1));
            bitcyc(ch, d);
        end
    endtask

    task automatic frame(input logic [23:0] l, input logic [23:0] r);
        half(1'b0, l, 24, SLOT);
        half(1'b1, r, 24, SLOT);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) bitcyc(1'b1, 1'($urandom_range(0, 1)));
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_lft"},   {16'b0, lft_smpl}, 32'd0);
        chk({tag, "_rht"},   {16'b0, rht_smpl}, 32'd0);
        chk({tag, "_valid"}, {31'b0, valid},    32'd0);
        chk({tag, "_ferr"},  {31'b0, frame_err}, 32'd0);
    endtask

    initial begin
        logic exp_ferr;
`ifdef I2S_FRAME_ERR_EN
        exp_ferr = 1'b1;
`else
        exp_ferr = 1'b0;
`endif
        rst_n = 1'b0;
        repeat (5) @(posedge clk);
        #1 check_zero_outputs("reset");
        rst_n = 1'b1;
        idle(4);

        // nominal frame
        exp_q.push_back('{l: 16'h1234, r: 16'hABCD});
        frame(24'h123456, 24'hABCDEF);
        idle(2);
        chk("nominal_drained", exp_q.size(), 32'd0);
        chk("rht_negative", {31'b0, $signed(rht_smpl) < 0}, 32'd1);

        // release reset partway through a right half
        rst_n = 1'b0;
        for (int i = 0; i < 6; i++) bitcyc(1'b1, 1'($urandom_range(0, 1)));
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) bitcyc(1'b1, 1'($urandom_range(0, 1)));
        chk("midstart_no_valid", vt.size(), 32'd1);
        exp_q.push_back('{l: 16'h2468, r: 16'h1357});
        frame(24'h2468AC, 24'h13579B);
        idle(2);
        chk("midstart_drained", exp_q.size(), 32'd0);

        // back-to-back frames
        vt.delete();
        exp_q.push_back('{l: 16'h7FFF, r: 16'h8000});
        exp_q.push_back('{l: 16'h0001, r: 16'hFFFF});
        exp_q.push_back('{l: 16'h55AA, r: 16'hAA55});
        frame(24'h7FFFFF, 24'h800000);
        frame(24'h000100, 24'hFFFF00);
        frame(24'h55AA55, 24'hAA55AA);
        idle(2);
        chk("b2b_count", vt.size(), 32'd3);
        if (vt.size() == 3) begin
            chk("b2b_spacing0", 32'(vt[1] - vt[0]), 32'(64 * 2 * SCLK_HALF));
            chk("b2b_spacing1", 32'(vt[2] - vt[1]), 32'(64 * 2 * SCLK_HALF));
        end

        // short left half (20 bits) followed by a full right half
        vt.delete();
        half(1'b0, 24'h999999, 20, 21);
        half(1'b1, 24'h111111, 24, SLOT);
        idle(2);
        chk("short_no_valid", vt.size(), 32'd0);
        chk("short_frame_err", {31'b0, frame_err}, {31'b0, exp_ferr});
        exp_q.push_back('{l: 16'h3C3C, r: 16'hC3C3});
        frame(24'h3C3C3C, 24'hC3C3C3);
        idle(2);
        chk("short_recover", vt.size(), 32'd1);
        chk("short_drained", exp_q.size(), 32'd0);

        // reset during a right half
        vt.delete();
        half(1'b0, 24'h5A5A5A, 24, SLOT);
        for (int i = 0; i < 10; i++) bitcyc(1'b1, 1'($urandom_range(0, 1)));
        rst_n = 1'b0;
        #1 check_zero_outputs("midreset");
        repeat (4) @(posedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 22; i++) bitcyc(1'b1, 1'($urandom_range(0, 1)));
        chk("midreset_no_valid", vt.size(), 32'd0);
        exp_q.push_back('{l: 16'h0F0F, r: 16'hF0F0});
        frame(24'h0F0F0F, 24'hF0F0F0);
        idle(2);
        chk("midreset_recover", vt.size(), 32'd1);

        chk("queue_drained", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
